// File: rtl/add_arb_pkg.sv
// Shared types and constants for the add_share_arb round-robin adder arbiter.
// Counter constants are used only when ADD_ARB_CNT_EN is defined.
package add_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int               CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

   // Saturating increment for the per-requester grant counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/add_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr+1,
// wrapping modulo N_REQ, so the requester at ptr has the lowest priority.
module rr_pick
   import add_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] cand;

   // Scanning from the far end down means the last hit is the nearest one after ptr.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      any  = |req;
      idx  = '0;
      cand = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         cand = ID_W'((int'(ptr) + i) % N_REQ);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one registered adder among N_REQ requesters, with a
// valid/ready response channel. Optional grant counters: define ADD_ARB_CNT_EN.
module add_share_arb
   import add_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [N_REQ*DATA_W-1:0]  i_a,
   input  logic [N_REQ*DATA_W-1:0]  i_b,
   output logic [N_REQ-1:0]         o_gnt,
   output logic                     o_vld,
   output logic [DATA_W:0]          o_sum,
   output logic [$clog2(N_REQ)-1:0] o_id,
   input  logic                     i_rdy
`ifdef ADD_ARB_CNT_EN
   ,output logic [N_REQ*CNT_W-1:0]  o_gnt_cnt
`endif
);

   localparam int ID_W = $clog2(N_REQ);

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [DATA_W-1:0] a_q, b_q;
   logic              pick_any;
   logic [ID_W-1:0]   pick_idx;

   rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req (i_req),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // NOTE: state and datapath registers use non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Unused encoding 2'd3 falls through to IDLE.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = pick_any ? BUSY : IDLE;
         BUSY:    state_nxt = RESP;
         RESP:    state_nxt = i_rdy ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_gnt  <= '0;
         o_vld  <= 1'b0;
         o_sum  <= '0;
         o_id   <= '0;
         rr_ptr <= ID_W'(N_REQ - 1);
         a_q    <= '0;
         b_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  a_q    <= i_a[pick_idx*DATA_W +: DATA_W];
                  b_q    <= i_b[pick_idx*DATA_W +: DATA_W];
                  o_gnt  <= N_REQ'(1) << pick_idx;
                  o_id   <= pick_idx;
                  rr_ptr <= pick_idx;
               end
            end
            BUSY: begin
               o_sum <= {1'b0, a_q} + {1'b0, b_q};
               o_gnt <= '0;
               o_vld <= 1'b1;
            end
            RESP: begin
               if (i_rdy) o_vld <= 1'b0;
            end
            default: begin
               o_gnt <= '0;
               o_vld <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADD_ARB_CNT_EN
   for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge i_clk) begin
         if (!i_rst_n)      cnt <= '0;
         else if (o_gnt[k]) cnt <= sat_inc(cnt);
      end
      assign o_gnt_cnt[k*CNT_W +: CNT_W] = cnt;
   end
`else
   // Grant counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a transaction-level model predicts grants and
// responses at each negedge; the driver applies directed and random stimulus.
module tb_add_share_arb;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 4;
   localparam int ID_W   = 2;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [N_REQ-1:0]        i_req;
   logic [N_REQ*DATA_W-1:0] i_a, i_b;
   logic [N_REQ-1:0]        o_gnt;
   logic                    o_vld;
   logic [DATA_W:0]         o_sum;
   logic [ID_W-1:0]         o_id;
   logic                    i_rdy;
`ifdef ADD_ARB_CNT_EN
   logic [N_REQ*8-1:0]      o_gnt_cnt;
`endif

   always #5 clk = ~clk;

   add_share_arb #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (i_req),
      .i_a     (i_a),
      .i_b     (i_b),
      .o_gnt   (o_gnt),
      .o_vld   (o_vld),
      .o_sum   (o_sum),
      .o_id    (o_id),
      .i_rdy   (i_rdy)
`ifdef ADD_ARB_CNT_EN
      ,.o_gnt_cnt (o_gnt_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      int id;
      int sum;
   } resp_t;

   resp_t            exp_q[$];
   int               gnt_log[$];
   int               m_ptr;
   int               m_stage;   // 0 no transaction, 1 grant just issued, 2 response waiting
   logic [N_REQ-1:0] exp_gnt;
   logic             exp_vld;
   bit               exp_zero;
   bit               armed = 0;
   int               n_done = 0;
   int               last_sum, last_id;

   // At a negedge the inputs are exactly what the next posedge will sample.
   always @(negedge clk) begin
      int w;
      logic [DATA_W-1:0] a, b;
      if (armed) begin
         check("gnt", o_gnt, exp_gnt);
         check("vld", o_vld, exp_vld);
         if (exp_zero) begin
            check("rst_sum", o_sum, 0);
            check("rst_id", o_id, 0);
         end
         if (exp_vld && exp_q.size() > 0) begin
            check("sum", o_sum, exp_q[0].sum);
            check("id", o_id, exp_q[0].id);
         end
         if (o_gnt != 0) gnt_log.push_back(int'(o_id));
      end
      exp_zero = 0;
      if (!rst_n) begin
         armed    = 1;
         m_ptr    = N_REQ - 1;
         m_stage  = 0;
         exp_q.delete();
         exp_gnt  = '0;
         exp_vld  = 1'b0;
         exp_zero = 1;
      end else if (armed) begin
         case (m_stage)
            0: begin
               exp_gnt = '0;
               exp_vld = 1'b0;
               if (i_req != 0) begin
                  w = -1;
                  for (int s = 1; s <= N_REQ; s++)
                     if (w < 0 && i_req[(m_ptr + s) % N_REQ]) w = (m_ptr + s) % N_REQ;
                  a = i_a[w*DATA_W +: DATA_W];
                  b = i_b[w*DATA_W +: DATA_W];
                  exp_gnt = N_REQ'(1) << w;
                  exp_q.push_back('{w, int'(a) + int'(b)});
                  m_ptr   = w;
                  m_stage = 1;
               end
            end
            1: begin
               exp_gnt = '0;
               exp_vld = 1'b1;
               m_stage = 2;
            end
            default: begin
               exp_gnt = '0;
               if (i_rdy) begin
                  last_sum = int'(o_sum);
                  last_id  = int'(o_id);
                  void'(exp_q.pop_front());
                  n_done++;
                  exp_vld = 1'b0;
                  m_stage = 0;
               end else begin
                  exp_vld = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- driver ----------------
   bit auto_drop = 1;
   bit scramble  = 0;

   task automatic set_op(input int k, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      i_a[k*DATA_W +: DATA_W] = a;
      i_b[k*DATA_W +: DATA_W] = b;
   endtask

   // Requesters drop their request in the grant cycle; scrambled operands test capture.
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drop) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (o_gnt[k]) begin
               i_req[k] = 1'b0;
               if (scramble) set_op(k, DATA_W'($urandom), DATA_W'($urandom));
            end
         end
      end
   endtask

   task automatic wait_gnt(input string name);
      bit ok = 0;
      for (int c = 0; c < 40 && !ok; c++) begin
         tick();
         if (o_gnt != 0) ok = 1;
      end
      check({name, "_gnt_timeout"}, ok, 1);
   endtask

   task automatic wait_done(input string name, input int target);
      for (int c = 0; c < 200 && n_done < target; c++) tick();
      check({name, "_done_timeout"}, n_done >= target, 1);
   endtask

   task automatic drain(input string name);
      i_req = '0;
      i_rdy = 1'b1;
      for (int c = 0; c < 20 && !(m_stage == 0 && exp_q.size() == 0); c++) tick();
      check({name, "_drain"}, (m_stage == 0 && exp_q.size() == 0), 1);
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int target;
      rst_n = 1'b0;
      i_req = '1;
      i_rdy = 1'b1;
      i_a   = N_REQ*DATA_W'($urandom);
      i_b   = N_REQ*DATA_W'($urandom);

      // Reset held with all requests active: model expects all-zero outputs.
      repeat (3) tick();
      i_req = '0;
      rst_n = 1'b1;
      tick();

      // Single request from requester 1.
      set_op(1, 4'h3, 4'h5);
      i_req  = 4'b0010;
      target = n_done + 1;
      wait_gnt("single");
      check("single_gnt", o_gnt, 4'b0010);
      wait_done("single", target);
      check("single_sum", last_sum, 8);
      check("single_id", last_id, 1);

      // Fairness from a fresh reset: all requesters held high.
      do_reset(1);
      auto_drop = 0;
      i_req = '1;
      gnt_log.delete();
      for (int c = 0; c < 100 && gnt_log.size() < 8; c++) tick();
      check("fair_count", gnt_log.size() >= 8, 1);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) check("fair_order", gnt_log[i], i % N_REQ);
      auto_drop = 1;
      drain("fair");

      // Backpressure: response held while others request; no grant until handshake.
      i_rdy = 1'b0;
      set_op(3, DATA_W'($urandom), DATA_W'($urandom));
      i_req  = 4'b1000;
      target = n_done + 4;
      wait_gnt("bp");
      for (int c = 0; c < 5 && !o_vld; c++) tick();
      i_req = 4'b0111;
      repeat (5) tick();
      i_rdy = 1'b1;
      wait_done("bp", target);
      drain("bp");

      // Maximum operands.
      set_op(0, 4'hF, 4'hF);
      i_req  = 4'b0001;
      target = n_done + 1;
      wait_gnt("max");
      wait_done("max", target);
      check("max_sum", last_sum, 'h1E);

      // Reset during BUSY drops the transaction; priority restarts at requester 0.
      set_op(2, DATA_W'($urandom), DATA_W'($urandom));
      i_req  = 4'b0100;
      target = n_done;
      wait_gnt("midrst");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      i_req = '1;
      wait_gnt("midrst_next");
      check("midrst_id", o_id, 0);
      check("midrst_lost", n_done, target);
      drain("midrst");

      // Randomized traffic with scrambled operands after capture.
      scramble = 1;
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int k = 0; k < N_REQ; k++) begin
            if (!i_req[k] && !o_gnt[k] && $urandom_range(3) == 0) begin
               set_op(k, DATA_W'($urandom), DATA_W'($urandom));
               i_req[k] = 1'b1;
            end
         end
         i_rdy = ($urandom_range(3) != 0);
      end
      scramble = 0;
      drain("rand");

`ifdef ADD_ARB_CNT_EN
      // 300 grants to requester 2: its counter saturates, the rest stay zero.
      do_reset(1);
      auto_drop = 0;
      i_req = 4'b0100;
      gnt_log.delete();
      for (int c = 0; c < 2000 && gnt_log.size() < 300; c++) tick();
      check("cnt_grants", gnt_log.size() >= 300, 1);
      auto_drop = 1;
      drain("cnt");
      for (int k = 0; k < N_REQ; k++)
         check("cnt_val", o_gnt_cnt[k*8 +: 8], (k == 2) ? 8'hFF : 8'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
